// File: rtl/bus_fifo_regs.sv
// Register-mapped host bridge with a TX FIFO (host to fabric) and an RX FIFO (fabric to host).
// The bus slave writes DATA to push TX, reads DATA to pop RX, and reads STATUS and the fill levels.
// The CTRL register flushes either FIFO and clears the sticky error flags.
module bus_fifo_regs #(
    parameter int unsigned DATW       = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // Register bus
    input  logic            do_write_i,
    input  logic            do_read_i,
    input  logic [1:0]      rw_adr_i,
    input  logic [DATW-1:0] w_data_i,
    output logic [DATW-1:0] read_data_o,
    // Stream out of the TX FIFO
    output logic            m_valid_o,
    output logic [DATW-1:0] m_data_o,
    input  logic            m_ready_i,
    // Stream into the RX FIFO
    input  logic            s_valid_i,
    input  logic [DATW-1:0] s_data_i,
    output logic            s_ready_o,
    output logic            irq_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

    localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
    // XOR of the two pointers equals this exactly when the FIFO is full
    localparam logic [PtrW-1:0] PtrMsb = PtrW'(1) << DEPTH_LOG2;

    localparam logic [1:0] AdrData   = 2'd0;
    localparam logic [1:0] AdrStatus = 2'd1;
    localparam logic [1:0] AdrRxLvl  = 2'd2;
    localparam logic [1:0] AdrCtrl   = 2'd3;

    // Storage, deliberately not reset
    logic [DATW-1:0] tx_mem [Depth];
    logic [DATW-1:0] rx_mem [Depth];

    // Pointers carry one extra wrap bit to tell full from empty
    logic [PtrW-1:0] tx_wr_q, tx_wr_d;
    logic [PtrW-1:0] tx_rd_q, tx_rd_d;
    logic [PtrW-1:0] rx_wr_q, rx_wr_d;
    logic [PtrW-1:0] rx_rd_q, rx_rd_d;

    logic            tx_ovf_q, tx_ovf_d;
    logic            rx_unf_q, rx_unf_d;
    logic [DATW-1:0] read_data_q, read_data_d;

    logic            tx_empty, tx_full;
    logic            rx_empty, rx_full;
    logic [PtrW-1:0] tx_lvl, rx_lvl;
    logic [5:0]      status;

    logic            wr_data, wr_ctrl, rd_data;
    logic            tx_push, tx_pop, tx_ovf_set, tx_flush;
    logic            rx_push, rx_pop, rx_unf_set, rx_flush;
    logic            clr_err;

    // FIFO flags and occupancy derived from the registered pointers
    always_comb begin
        tx_empty = (tx_wr_q == tx_rd_q);
        tx_full  = ((tx_wr_q ^ tx_rd_q) == PtrMsb);
        rx_empty = (rx_wr_q == rx_rd_q);
        rx_full  = ((rx_wr_q ^ rx_rd_q) == PtrMsb);
        tx_lvl   = tx_wr_q - tx_rd_q;
        rx_lvl   = rx_wr_q - rx_rd_q;
        status   = {rx_unf_q, tx_ovf_q, rx_full, rx_empty, tx_full, tx_empty};
    end

    // Stream handshakes and interrupt; all forced low while reset is held
    always_comb begin
        m_valid_o   = !tx_empty && !rst_i;
        m_data_o    = tx_mem[tx_rd_q[DEPTH_LOG2-1:0]];
        s_ready_o   = !rx_full && !rst_i;
        irq_o       = !rst_i && (!rx_empty || tx_ovf_q || rx_unf_q);
        read_data_o = read_data_q;
    end

    // Bus decode into push/pop/flush strobes, all judged on pre-edge state
    always_comb begin
        wr_data    = do_write_i && (rw_adr_i == AdrData);
        wr_ctrl    = do_write_i && (rw_adr_i == AdrCtrl);
        rd_data    = do_read_i && (rw_adr_i == AdrData);

        tx_push    = wr_data && !tx_full;
        tx_ovf_set = wr_data && tx_full;
        tx_pop     = m_valid_o && m_ready_i;
        tx_flush   = wr_ctrl && w_data_i[0];

        rx_push    = s_valid_i && s_ready_o;
        rx_pop     = rd_data && !rx_empty;
        rx_unf_set = rd_data && rx_empty;
        rx_flush   = wr_ctrl && w_data_i[1];

        clr_err    = wr_ctrl && w_data_i[2];
    end

    // Next pointer values; a flush overrides any same-cycle push or pop
    always_comb begin
        tx_wr_d = tx_wr_q;
        tx_rd_d = tx_rd_q;
        rx_wr_d = rx_wr_q;
        rx_rd_d = rx_rd_q;

        if (tx_flush) begin
            tx_wr_d = '0;
            tx_rd_d = '0;
        end else begin
            if (tx_push) tx_wr_d = tx_wr_q + PtrOne;
            if (tx_pop)  tx_rd_d = tx_rd_q + PtrOne;
        end

        if (rx_flush) begin
            rx_wr_d = '0;
            rx_rd_d = '0;
        end else begin
            if (rx_push) rx_wr_d = rx_wr_q + PtrOne;
            if (rx_pop)  rx_rd_d = rx_rd_q + PtrOne;
        end
    end

    // Sticky error flags: set on overflow/underflow, cleared only through CTRL bit 2
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        if (clr_err) begin
            tx_ovf_d = 1'b0;
            rx_unf_d = 1'b0;
        end else begin
            if (tx_ovf_set) tx_ovf_d = 1'b1;
            if (rx_unf_set) rx_unf_d = 1'b1;
        end
    end

    // Read mux captured on the strobe cycle and held until the next read
    always_comb begin
        read_data_d = read_data_q;
        if (do_read_i) begin
            case (rw_adr_i)
                AdrData:   read_data_d = rx_empty ? '0 : rx_mem[rx_rd_q[DEPTH_LOG2-1:0]];
                AdrStatus: read_data_d = DATW'(status);
                AdrRxLvl:  read_data_d = DATW'(rx_lvl);
                AdrCtrl:   read_data_d = DATW'(tx_lvl);
                default:   read_data_d = '0;
            endcase
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr_q     <= '0;
            tx_rd_q     <= '0;
            rx_wr_q     <= '0;
            rx_rd_q     <= '0;
            tx_ovf_q    <= 1'b0;
            rx_unf_q    <= 1'b0;
            read_data_q <= '0;
        end else begin
            tx_wr_q     <= tx_wr_d;
            tx_rd_q     <= tx_rd_d;
            rx_wr_q     <= rx_wr_d;
            rx_rd_q     <= rx_rd_d;
            tx_ovf_q    <= tx_ovf_d;
            rx_unf_q    <= rx_unf_d;
            read_data_q <= read_data_d;
        end
    end

    // RAM writes at the current write pointers
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr_q[DEPTH_LOG2-1:0]] <= w_data_i;
        if (rx_push) rx_mem[rx_wr_q[DEPTH_LOG2-1:0]] <= s_data_i;
    end

endmodule

// File: tb/tb_bus_fifo_regs.sv
// Scoreboard bench for bus_fifo_regs: the driver updates a queue-based model and pushes
// expectations; a negedge monitor pops and compares whenever the DUT presents a result.
module tb_bus_fifo_regs;

    localparam int unsigned DATW       = 8;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int          Depth      = 16;

    logic            clk;
    logic            rst      = 1'b1;
    logic            do_write = 1'b0;
    logic            do_read  = 1'b0;
    logic [1:0]      rw_adr   = '0;
    logic [DATW-1:0] w_data   = '0;
    logic [DATW-1:0] read_data;
    logic            m_valid;
    logic [DATW-1:0] m_data;
    logic            m_ready  = 1'b0;
    logic            s_valid  = 1'b0;
    logic [DATW-1:0] s_data   = '0;
    logic            s_ready;
    logic            irq;

    bus_fifo_regs #(
        .DATW       (DATW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .do_write_i  (do_write),
        .do_read_i   (do_read),
        .rw_adr_i    (rw_adr),
        .w_data_i    (w_data),
        .read_data_o (read_data),
        .m_valid_o   (m_valid),
        .m_data_o    (m_data),
        .m_ready_i   (m_ready),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_ready_o   (s_ready),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            mv;
        logic [DATW-1:0] head;
        logic            sr;
        logic            irq;
    } cyc_t;

    // Expectation queues
    cyc_t            exp_cyc[$];
    logic [DATW-1:0] exp_rd[$];
    logic [DATW-1:0] exp_m[$];

    // Reference model
    logic [DATW-1:0] tx_m[$];
    logic [DATW-1:0] rx_m[$];
    bit              ovf_m = 1'b0;
    bit              unf_m = 1'b0;

    int errors = 0;
    int checks = 0;
    bit done    = 1'b0;
    bit drained = 1'b0;

    function automatic logic [DATW-1:0] model_read(input logic [1:0] a);
        logic [5:0] st;
        case (a)
            2'd0: return (rx_m.size() == 0) ? '0 : rx_m[0];
            2'd1: begin
                st = {unf_m, ovf_m, rx_m.size() == Depth, rx_m.size() == 0,
                      tx_m.size() == Depth, tx_m.size() == 0};
                return DATW'(st);
            end
            2'd2: return DATW'(rx_m.size());
            default: return DATW'(tx_m.size());
        endcase
    endfunction

    // Drive one clock cycle of stimulus and advance the model across the edge
    task automatic cyc(input bit wr, input bit rd, input logic [1:0] a, input logic [DATW-1:0] wd,
                       input bit mr, input bit sv, input logic [DATW-1:0] sd);
        cyc_t            rec;
        logic [DATW-1:0] tmp;
        bit              txpop, txpush, rxpop, rxpush, wr0, rd0, ctl;
        do_write = wr;
        do_read  = rd;
        rw_adr   = a;
        w_data   = wd;
        m_ready  = mr;
        s_valid  = sv;
        s_data   = sd;

        rec.mv   = (tx_m.size() != 0);
        rec.head = rec.mv ? tx_m[0] : '0;
        rec.sr   = (rx_m.size() < Depth);
        rec.irq  = (rx_m.size() != 0) || ovf_m || unf_m;
        exp_cyc.push_back(rec);
        if (rd) exp_rd.push_back(model_read(a));

        wr0    = wr && (a == 2'd0);
        rd0    = rd && (a == 2'd0);
        ctl    = wr && (a == 2'd3);
        txpop  = mr && (tx_m.size() != 0);
        txpush = wr0 && (tx_m.size() < Depth);
        rxpop  = rd0 && (rx_m.size() != 0);
        rxpush = sv && (rx_m.size() < Depth);
        if (wr0 && !txpush) ovf_m = 1'b1;
        if (rd0 && !rxpop)  unf_m = 1'b1;
        if (txpop) begin
            tmp = tx_m.pop_front();
            exp_m.push_back(tmp);
        end
        if (txpush) tx_m.push_back(wd);
        if (rxpop) tmp = rx_m.pop_front();
        if (rxpush) rx_m.push_back(sd);
        if (ctl) begin
            if (wd[0]) tx_m.delete();
            if (wd[1]) rx_m.delete();
            if (wd[2]) begin
                ovf_m = 1'b0;
                unf_m = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [DATW-1:0] d);
        cyc(1'b1, 1'b0, a, d, 1'b0, 1'b0, '0);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        cyc(1'b0, 1'b1, a, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        do_write = 1'b0;
        do_read  = 1'b0;
        rw_adr   = '0;
        w_data   = '0;
        m_ready  = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        tx_m.delete();
        rx_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        exp_rd.delete();
        exp_m.delete();
        exp_cyc.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples mid-cycle, away from the active edge
    logic [DATW-1:0] cur_exp  = '0;
    bit              pending  = 1'b0;
    bit              rst_prev = 1'b0;
    cyc_t            rec_mon;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_m_valid", 32'(m_valid), 32'd0);
            chk("rst_s_ready", 32'(s_ready), 32'd0);
            chk("rst_irq", 32'(irq), 32'd0);
            if (rst_prev) chk("rst_read_data", 32'(read_data), 32'd0);
            pending = 1'b0;
            cur_exp = '0;
        end else if (done) begin
            if (!drained) begin
                chk("queues_drained", 32'(exp_rd.size() + exp_m.size() + exp_cyc.size()), 32'd0);
                drained = 1'b1;
            end
        end else begin
            if (pending) begin
                if (exp_rd.size() == 0) begin
                    chk("read_expectation_present", 32'd0, 32'd1);
                end else begin
                    cur_exp = exp_rd.pop_front();
                end
                pending = 1'b0;
            end
            chk("read_data", 32'(read_data), 32'(cur_exp));
            if (exp_cyc.size() == 0) begin
                chk("cycle_expectation_present", 32'd0, 32'd1);
            end else begin
                rec_mon = exp_cyc.pop_front();
                chk("m_valid", 32'(m_valid), 32'(rec_mon.mv));
                chk("s_ready", 32'(s_ready), 32'(rec_mon.sr));
                chk("irq", 32'(irq), 32'(rec_mon.irq));
                if (rec_mon.mv) chk("m_data_head", 32'(m_data), 32'(rec_mon.head));
            end
            if (m_valid && m_ready) begin
                if (exp_m.size() == 0) begin
                    chk("m_handshake_expected", 32'd0, 32'd1);
                end else begin
                    chk("m_handshake_data", 32'(m_data), 32'(exp_m.pop_front()));
                end
            end
            if (do_read) pending = 1'b1;
        end
        rst_prev = rst;
    end

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit              fill;
        int              op;
        logic [1:0]      a;
        logic [DATW-1:0] d;
        bit              mr, sv;

        do_reset(3);

        // Single TX write held with m_ready low, then TX level
        wr_reg(2'd0, 8'hA5);
        rd_reg(2'd3);
        idle();

        // Overfill TX, then clear the sticky flags
        wr_reg(2'd3, 8'h07);
        for (int i = 0; i < 17; i++) wr_reg(2'd0, DATW'(i + 8'h30));
        rd_reg(2'd3);
        rd_reg(2'd1);
        wr_reg(2'd3, 8'h04);
        rd_reg(2'd1);
        wr_reg(2'd1, 8'hFF);
        wr_reg(2'd2, 8'hFF);
        rd_reg(2'd1);

        // Drain TX through the stream port
        for (int i = 0; i < 18; i++) cyc(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, '0);

        // RX push of two words, then read them back
        cyc(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 8'h22);
        rd_reg(2'd0);
        rd_reg(2'd0);
        rd_reg(2'd2);
        idle();

        // Underflow read
        rd_reg(2'd0);
        rd_reg(2'd1);
        wr_reg(2'd3, 8'h04);

        // RX full: pop with refused push, then the push lands
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, DATW'(8'h80 + i));
        rd_reg(2'd1);
        cyc(1'b0, 1'b1, 2'd0, '0, 1'b0, 1'b1, 8'h99);
        rd_reg(2'd2);
        cyc(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 8'h77);
        rd_reg(2'd2);

        // Flush both while streams are active
        wr_reg(2'd0, 8'h01);
        wr_reg(2'd0, 8'h02);
        cyc(1'b1, 1'b0, 2'd3, 8'h03, 1'b1, 1'b1, 8'h66);
        rd_reg(2'd2);
        rd_reg(2'd3);

        // Reset with data buffered in both FIFOs
        wr_reg(2'd0, 8'h09);
        cyc(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 8'h5A);
        rd_reg(2'd1);
        do_reset(3);
        rd_reg(2'd1);
        idle();

        // Randomised traffic with alternating fill/drain bias
        fill = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) fill = ~fill;
            if ($urandom_range(0, 999) == 0) do_reset(2);
            op = $urandom_range(0, 7);
            d  = DATW'($urandom);
            mr = fill ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
            sv = fill ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
            if (op <= 2) begin
                if ($urandom_range(0, 15) == 0) a = 2'd3;
                else if ($urandom_range(0, 7) == 0) a = 2'($urandom_range(1, 2));
                else a = 2'd0;
                cyc(1'b1, 1'b0, a, d, mr, sv, DATW'($urandom));
            end else if (op <= 5) begin
                a = 2'($urandom_range(0, 3));
                cyc(1'b0, 1'b1, a, '0, mr, sv, DATW'($urandom));
            end else begin
                cyc(1'b0, 1'b0, 2'd0, '0, mr, sv, DATW'($urandom));
            end
        end

        repeat (3) idle();
        done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
